// File: rtl/tkz_counter_tx_if.sv
// tkz_counter_tx_if: 32-bit beat stream carrying the tweakey-Z image to the datapath
interface tkz_counter_tx_if;
   logic [31:0] tkz_word;
   logic        tkz_valid;
   logic        tkz_ready;
   logic        tkz_last;
   modport master (output tkz_word, tkz_valid, tkz_last, input tkz_ready);
   modport slave (input tkz_word, tkz_valid, tkz_last, output tkz_ready);
endinterface

// File: rtl/tkz_counter_tx.sv
// tkz_counter_tx: Romulus block-counter LFSR plus domain byte, shipped as a two-beat TK1 snapshot
module tkz_counter_tx #(
   parameter logic [7:0]  POLY     = 8'h95,
   parameter logic [55:0] INIT_CNT = 56'h1,
   parameter logic [7:0]  INIT_DOM = 8'h00
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cnt_init,
   input  logic                     cnt_step,
   input  logic                     dom_ld,
   input  logic [7:0]               dom_in,
   input  logic                     send,
   tkz_counter_tx_if.master         tkz,
   output logic                     busy,
   output logic [63:0]              tkz_image
);
   typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
   state_t      state_q, state_d;
   logic [55:0] cnt_q, cnt_d;
   logic [7:0]  dom_q, dom_d;
   logic [63:0] snap_q, snap_d;
   // counter bytes are laid out LSB-first from the top of the image
   assign tkz_image = {cnt_q[7:0], cnt_q[15:8], cnt_q[23:16], cnt_q[31:24],
                       cnt_q[39:32], cnt_q[47:40], cnt_q[55:48], dom_q};
   assign tkz.tkz_valid = state_q != IDLE;
   assign tkz.tkz_last  = state_q == BEAT1;
   assign tkz.tkz_word  = state_q == BEAT0 ? snap_q[31:0] : state_q == BEAT1 ? snap_q[63:32] : 32'h0;
   assign busy          = state_q != IDLE;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= INIT_CNT;
         dom_q   <= INIT_DOM;
         snap_q  <= 64'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dom_q   <= dom_d;
         snap_q  <= snap_d;
      end
   end
   always_comb begin
      cnt_d   = cnt_init ? INIT_CNT
              : cnt_step ? {cnt_q[54:0], 1'b0} ^ (cnt_q[55] ? {48'h0, POLY} : 56'h0)
              : cnt_q;
      dom_d   = dom_ld ? dom_in : dom_q;
      state_d = state_q;
      snap_d  = snap_q;
      case (state_q)
         IDLE: if (send) begin
            snap_d  = tkz_image;
            state_d = BEAT0;
         end
         BEAT0: if (tkz.tkz_ready) state_d = BEAT1;
         BEAT1: if (tkz.tkz_ready) begin
            state_d = send ? BEAT0 : IDLE;
            snap_d  = send ? tkz_image : snap_q;
         end
         default: state_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_tkz_counter_tx.sv
// tb_tkz_counter_tx: directed stimulus with a beat scoreboard checked on every accepted beat
module tb_tkz_counter_tx;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cnt_init = 1'b0, cnt_step = 1'b0, dom_ld = 1'b0, send = 1'b0;
   logic [7:0]  dom_in = 8'h0;
   logic        busy;
   logic [63:0] tkz_image;
   int          vectors = 0, miscompares = 0;
   logic [32:0] sbq[$];
   tkz_counter_tx_if bus();
   tkz_counter_tx dut (
      .clk(clk), .rst(rst), .cnt_init(cnt_init), .cnt_step(cnt_step),
      .dom_ld(dom_ld), .dom_in(dom_in), .send(send), .tkz(bus),
      .busy(busy), .tkz_image(tkz_image)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   // accepted beats are compared against the scoreboard on the falling edge
   always @(negedge clk) begin
      if (!rst && bus.tkz_valid && bus.tkz_ready) begin
         if (sbq.size() == 0) chk("sb_underflow", 64'(sbq.size()), 64'd1);
         else chk("beat", {31'h0, bus.tkz_last, bus.tkz_word}, {31'h0, sbq.pop_front()});
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.tkz_ready = 1'b0;
      repeat (2) step();
      chk("rst_valid", {63'h0, bus.tkz_valid}, 64'h0);
      chk("rst_last", {63'h0, bus.tkz_last}, 64'h0);
      chk("rst_word", {32'h0, bus.tkz_word}, 64'h0);
      chk("rst_busy", {63'h0, busy}, 64'h0);
      chk("rst_image", tkz_image, 64'h0100000000000000);
      rst = 1'b0;
      // basic two-beat transfer
      bus.tkz_ready = 1'b1;
      send = 1'b1;
      sbq.push_back({1'b0, 32'h00000000});
      sbq.push_back({1'b1, 32'h01000000});
      step();
      send = 1'b0;
      chk("t1_busy", {63'h0, busy}, 64'h1);
      step();
      chk("t1_last", {63'h0, bus.tkz_last}, 64'h1);
      step();
      chk("t1_idle", {63'h0, busy}, 64'h0);
      // LFSR walk up to the feedback point
      cnt_step = 1'b1;
      repeat (55) step();
      cnt_step = 1'b0;
      chk("t2_step55", tkz_image, 64'h0000000000008000);
      cnt_step = 1'b1;
      step();
      cnt_step = 1'b0;
      chk("t2_step56", tkz_image, 64'h9500000000000000);
      // snapshot precedes same-cycle counter update
      rst = 1'b1;
      step();
      rst = 1'b0;
      dom_ld = 1'b1;
      dom_in = 8'h4A;
      step();
      dom_ld = 1'b0;
      send = 1'b1;
      cnt_step = 1'b1;
      sbq.push_back({1'b0, 32'h0000004A});
      sbq.push_back({1'b1, 32'h01000000});
      step();
      send = 1'b0;
      cnt_step = 1'b0;
      chk("t3_image", tkz_image, 64'h020000000000004A);
      repeat (2) step();
      chk("t3_idle", {63'h0, busy}, 64'h0);
      // stall in BEAT0 while the counter moves
      bus.tkz_ready = 1'b0;
      send = 1'b1;
      sbq.push_back({1'b0, 32'h0000004A});
      sbq.push_back({1'b1, 32'h02000000});
      step();
      send = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cnt_step = ~cnt_step;
         step();
         chk("t4_stall_word", {32'h0, bus.tkz_word}, 64'h0000004A);
         chk("t4_stall_last", {63'h0, bus.tkz_last}, 64'h0);
         chk("t4_stall_valid", {63'h0, bus.tkz_valid}, 64'h1);
      end
      cnt_step = 1'b0;
      bus.tkz_ready = 1'b1;
      repeat (2) step();
      chk("t4_idle", {63'h0, busy}, 64'h0);
      // back-to-back streaming
      cnt_init = 1'b1;
      step();
      cnt_init = 1'b0;
      chk("t5_init_image", tkz_image, 64'h010000000000004A);
      for (int i = 0; i < 4; i++) begin
         sbq.push_back({1'b0, 32'h0000004A});
         sbq.push_back({1'b1, 32'h01000000});
      end
      send = 1'b1;
      step();
      for (int i = 0; i < 8; i++) begin
         send = i < 6;
         chk("t5_busy", {63'h0, busy}, 64'h1);
         chk("t5_last", {63'h0, bus.tkz_last}, {63'h0, 1'(i % 2)});
         step();
      end
      chk("t5_idle", {63'h0, busy}, 64'h0);
      // reset in BEAT1 while stalled
      send = 1'b1;
      sbq.push_back({1'b0, 32'h0000004A});
      step();
      send = 1'b0;
      step();
      bus.tkz_ready = 1'b0;
      chk("t6_in_beat1", {63'h0, bus.tkz_last}, 64'h1);
      rst = 1'b1;
      #1;
      chk("t6_valid_async", {63'h0, bus.tkz_valid}, 64'h0);
      chk("t6_busy_async", {63'h0, busy}, 64'h0);
      step();
      rst = 1'b0;
      step();
      chk("t6_image", tkz_image, 64'h0100000000000000);
      chk("t6_word", {32'h0, bus.tkz_word}, 64'h0);
      chk("sb_drain", 64'(sbq.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
